// File: rtl/ssram_responder_if.sv
// SSRAM pin bundle as seen by the responder. The bidirectional DQ is split
// into write data in, read data out and a drive enable.
interface ssram_responder_if;
    logic        ssram_ce1_n;
    logic        ssram_ce2;
    logic        ssram_ce3_n;
    logic        ssram_adsc_n;
    logic        ssram_adsp_n;
    logic        ssram_adv_n;
    logic        ssram_oe_n;
    logic        ssram_gw_n;
    logic        ssram_bwe_n;
    logic [3:0]  ssram_be_n;
    logic [20:0] ssram_addr;
    logic [31:0] ssram_dq_i;
    logic [31:0] ssram_dq_o;
    logic        ssram_dq_oe;

    // Memory controller side: drives the strobes, sees the read data.
    modport master (
        output ssram_ce1_n, ssram_ce2, ssram_ce3_n, ssram_adsc_n, ssram_adsp_n,
               ssram_adv_n, ssram_oe_n, ssram_gw_n, ssram_bwe_n, ssram_be_n,
               ssram_addr, ssram_dq_i,
        input  ssram_dq_o, ssram_dq_oe
    );

    // SSRAM device side.
    modport slave (
        input  ssram_ce1_n, ssram_ce2, ssram_ce3_n, ssram_adsc_n, ssram_adsp_n,
               ssram_adv_n, ssram_oe_n, ssram_gw_n, ssram_bwe_n, ssram_be_n,
               ssram_addr, ssram_dq_i,
        output ssram_dq_o, ssram_dq_oe
    );
endinterface

// File: rtl/ssram_responder.sv
// Pipelined burst SSRAM stand-in. Decodes ADSC/ADSP starts, runs a 2-bit
// linear burst counter, performs byte-lane writes at the look-ahead address
// with no latency, and registers read data for a 2-cycle read pipeline.
module ssram_responder #(
    parameter int AW        = 16,
    parameter bit INIT_ZERO = 1'b1
) (
    input  logic               sys_clk,
    input  logic               reset,
    ssram_responder_if.slave   bus
);
    localparam int DEPTH = 1 << AW;

    // Backing store; contents come from configuration, never from reset.
    logic [31:0] mem [DEPTH] = '{default: (INIT_ZERO ? 32'h0 : 32'hx)};

    // Burst state
    logic          active;
    logic          rd_valid;
    logic          wr_last;
    logic [AW-3:0] base;
    logic [1:0]    cnt;
    logic [31:0]   rd_data;

    // Per-edge decode
    logic          ce_ok;
    logic          sel_c;
    logic          sel_p;
    logic          start;
    logic          desel;
    logic          wr_req;
    logic          wr_en;
    logic          rd_en;
    logic [1:0]    cnt_inc;
    logic [AW-1:0] ea;
    logic [AW-1:0] wr_addr;
    logic [3:0]    wr_lanes;

    // Address bits above the stored range alias onto the array.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.ssram_addr[20:AW];

    // Decode strobes, chip enables and the read/write targets for this edge.
    always_comb begin
        ce_ok    = !bus.ssram_ce1_n && bus.ssram_ce2 && !bus.ssram_ce3_n;
        sel_c    = !bus.ssram_adsc_n && ce_ok;
        // ADSP only needs ce1_n, and is dead whenever ce1_n is high.
        sel_p    = !bus.ssram_adsp_n && !bus.ssram_ce1_n;
        start    = sel_c || sel_p;
        desel    = !bus.ssram_adsc_n && !ce_ok;
        cnt_inc  = cnt + 2'd1;
        ea       = {base, cnt};
        wr_req   = !bus.ssram_gw_n || !bus.ssram_bwe_n;
        // An ADSP start is always read-type; an ADSC start may carry a write
        // even from idle, since it opens the burst on that same edge.
        wr_en    = wr_req && !sel_p && (sel_c || active);
        // Writes land at the address the counter is about to hold; on an
        // ADSC start that is the freshly strobed address (ADV is ignored).
        wr_addr  = sel_c ? bus.ssram_addr[AW-1:0]
                         : {base, (bus.ssram_adv_n ? cnt : cnt_inc)};
        wr_lanes = !bus.ssram_gw_n ? 4'hF : ~bus.ssram_be_n;
        rd_en    = active && !wr_en;
    end

    // Burst control and read pipeline register.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            active   <= 1'b0;
            rd_valid <= 1'b0;
            wr_last  <= 1'b0;
            base     <= '0;
            cnt      <= '0;
            rd_data  <= '0;
        end else begin
            if (start) begin
                base   <= bus.ssram_addr[AW-1:2];
                cnt    <= bus.ssram_addr[1:0];
                active <= 1'b1;
            end else if (desel) begin
                active <= 1'b0;
            end else if (active && !bus.ssram_adv_n) begin
                cnt    <= cnt_inc;
            end
            // Reads use the pre-advance address; writes leave rd_data alone.
            if (rd_en) rd_data <= mem[ea];
            rd_valid <= rd_en;
            wr_last  <= wr_en;
        end
    end

    // Byte-lane array write; a write coinciding with reset is dropped.
    always_ff @(posedge sys_clk) begin
        if (!reset && wr_en) begin
            for (int n = 0; n < 4; n++) begin
                if (wr_lanes[n]) mem[wr_addr][8*n +: 8] <= bus.ssram_dq_i[8*n +: 8];
            end
        end
    end

    assign bus.ssram_dq_o  = rd_data;
    // OE is asynchronous; suppress drive for the turnaround after a write.
    assign bus.ssram_dq_oe = !bus.ssram_oe_n && rd_valid && !wr_last;

endmodule
